dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller for the MIPS datapath.
- Sits directly upstream of the 16-entry valid-bit array and the companion tag/data arrays.
- Decodes CPU address into index/tag and reads the arrays combinationally to decide hit/miss.
- Sequences line fills, write-throughs and whole-cache flush toward external memory, and drives the arrays' write ports (index, write enable, write data).

Parameters:
- IDX_W, 4, index width; LINES = 2**IDX_W = 16.
- TAG_W, 26, tag width = 32 - IDX_W - 2.
- DATA_W, 32, word width.
- CNT_W, 16, width of hit/miss statistic counters.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request; address/data held stable until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address: tag = [31:6], index = [5:2], [1:0] ignored.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data, valid while cpu_ready=1.
- cpu_ready  out  1  access complete (1-cycle pulse per access).
- flush  in  1  request invalidation of all lines.
- flush_busy  out  1  high while in FLUSH.
- arr_index  out  IDX_W  index to valid/tag/data arrays.
- valid_in  in  1  valid-array read at arr_index.
- tag_in  in  TAG_W  tag-array read at arr_index.
- data_in  in  DATA_W  data-array read at arr_index.
- valid_wen / valid_wr  out  1/1  valid-array write enable / write bit.
- tag_wen / tag_wr  out  1/TAG_W  tag-array write enable / data.
- data_wen / data_wr  out  1/DATA_W  data-array write enable / data.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  32  word-aligned address {cpu_addr[31:2],2'b00}.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  1-cycle completion strobe.
- hit_cnt / miss_cnt  out  CNT_W  load hit / load miss counters.

Behaviour:
- States:
  - IDLE: flush has priority over cpu_req.
    - flush=1 -> FLUSH.
    - Load, hit: stay IDLE.
    - Load, miss -> RFILL.
    - Store -> WTHRU.
  - RFILL: mem_ack -> IDLE.
  - WTHRU: mem_ack -> IDLE.
  - FLUSH: when flush counter = LINES-1 -> IDLE.
- hit = valid_in & (tag_in == cpu_addr[31:6]), combinational.
- Load hit: cpu_ready=1 and cpu_rdata=data_in in the same cycle (zero wait). hit_cnt += 1.
- Load miss:
  - Next cycle: mem_req=1, mem_we=0.
  - On mem_ack cycle: valid_wen=tag_wen=data_wen=1, valid_wr=1, tag_wr=cpu_addr[31:6], data_wr=mem_rdata, cpu_ready=1, cpu_rdata=mem_rdata.
  - miss_cnt += 1 at acceptance.
- Store:
  - If hit, data_wen=1 with data_wr=cpu_wdata in the IDLE acceptance cycle. A miss store leaves the arrays untouched.
  - WTHRU: mem_req=1, mem_we=1, mem_wdata=cpu_wdata; cpu_ready=1 on mem_ack.
  - Stores do not change the counters.
- mem_req/mem_we/mem_addr/mem_wdata are registered. mem_req deasserts the cycle after mem_ack. mem_ack outside RFILL/WTHRU is ignored.
- FLUSH:
  - 4-bit counter 0..15; each cycle valid_wen=1, valid_wr=0, arr_index=counter. Takes exactly 16 cycles.
  - cpu_ready=0 throughout; flush_busy=1.
  - flush is sampled only in IDLE.
- arr_index = cpu_addr[5:2] in all states except FLUSH.
- All write enables are 0 unless stated above.
- Counters saturate at 2**CNT_W-1 and do not wrap.
- Back-to-back: a new cpu_req may be accepted in the cycle after cpu_ready.
- Reset (rst=0 at clk edge):
  - state=IDLE; flush counter=0; hit_cnt=miss_cnt=0.
  - mem_req=mem_we=0, mem_addr=mem_wdata=0; cpu_ready=0, cpu_rdata=0; all wen=0; flush_busy=0.
  - Reset mid-RFILL/WTHRU abandons the access: no array write, mem_req low from the next cycle.
  - The valid array is cleared by the same rst.

Test Plan:
- Reset, load 0x00000040 (index 0, invalid) -> mem_req=1, mem_addr=0x00000040 next cycle. mem_ack with rdata=0xDEADBEEF -> cpu_ready=1, rdata=0xDEADBEEF, valid/tag/data wen=1 at index 0, miss_cnt=1.
- Repeat load 0x00000040 -> cpu_ready same cycle, rdata=0xDEADBEEF, no mem_req, hit_cnt=1.
- Load 0x00000080 (same index, tag 2) -> miss and refill. Then load 0x00000040 -> miss again (conflict); miss_cnt=3.
- Store 0x00000080 data 0x12345678 on hit -> data_wen=1 at index 0 in the acceptance cycle, mem_we=1, cpu_ready only on mem_ack. Store to 0x00000104 (miss) -> no array writes.
- flush with cpu_req also high -> FLUSH entered; 16 cycles of valid_wen=1, valid_wr=0, indices 0..15. Next load 0x00000080 misses.
- rst=0 two cycles after a load miss issues mem_req -> mem_req=0 the next cycle, no wen, counters 0. Late mem_ack is ignored.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller. The valid/tag/data arrays live outside this block; the
// controller reads them at arr_index and drives their write ports.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   cpu_req/we/addr/wdata    CPU access, held until cpu_ready
//   cpu_rdata, cpu_ready     load data and 1-cycle completion pulse
//   flush, flush_busy        invalidate-all request / in-progress flag
//   arr_index                shared index to the three arrays
//   valid_in/tag_in/data_in  array read data at arr_index
//   *_wen/*_wr               array write enables and write data
//   mem_req/we/addr/wdata    registered memory request, held until mem_ack
//   mem_rdata, mem_ack       memory read data and completion strobe
//   hit_cnt, miss_cnt        saturating load hit/miss counters
//
// state | meaning
// IDLE  | decode hit/miss; load hits complete here with no wait
// RFILL | load miss, waiting on memory; line written on mem_ack
// WTHRU | store forwarded to memory, waiting on mem_ack
// FLUSH | clearing one valid bit per cycle, index 0..LINES-1

module dcache_ctrl #(
   parameter int IDX_W  = 4,
   parameter int TAG_W  = 26,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   input  logic              flush,
   output logic              flush_busy,
   output logic [IDX_W-1:0]  arr_index,
   input  logic              valid_in,
   input  logic [TAG_W-1:0]  tag_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              valid_wen,
   output logic              valid_wr,
   output logic              tag_wen,
   output logic [TAG_W-1:0]  tag_wr,
   output logic              data_wen,
   output logic [DATA_W-1:0] data_wr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   typedef enum logic [1:0] {IDLE, RFILL, WTHRU, FLUSH} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   flush_cnt;
   logic [TAG_W-1:0]   addr_tag;
   logic [IDX_W-1:0]   addr_idx;
   logic               hit;
   logic               cnt_hit, cnt_miss;
   logic               mem_start, mem_done;
   logic               unused_byte_sel;

   assign addr_tag        = cpu_addr[31:IDX_W+2];
   assign addr_idx        = cpu_addr[IDX_W+1:2];
   assign hit             = valid_in && (tag_in == addr_tag);
   assign unused_byte_sel = ^cpu_addr[1:0];

   always_comb begin
      state_nxt  = state;
      cpu_ready  = 1'b0;
      cpu_rdata  = '0;
      flush_busy = 1'b0;
      arr_index  = addr_idx;
      valid_wen  = 1'b0;
      valid_wr   = 1'b0;
      tag_wen    = 1'b0;
      tag_wr     = addr_tag;
      data_wen   = 1'b0;
      data_wr    = '0;
      cnt_hit    = 1'b0;
      cnt_miss   = 1'b0;
      mem_start  = 1'b0;
      mem_done   = 1'b0;
      // While reset is asserted every output stays at its idle default.
      if (rst) begin
         unique case (state)
            IDLE: begin
               if (flush) begin
                  state_nxt = FLUSH;
               end else if (cpu_req) begin
                  if (cpu_we) begin
                     state_nxt = WTHRU;
                     mem_start = 1'b1;
                     // Update in place only when the line is resident.
                     if (hit) begin
                        data_wen = 1'b1;
                        data_wr  = cpu_wdata;
                     end
                  end else if (hit) begin
                     cpu_ready = 1'b1;
                     cpu_rdata = data_in;
                     cnt_hit   = 1'b1;
                  end else begin
                     state_nxt = RFILL;
                     mem_start = 1'b1;
                     cnt_miss  = 1'b1;
                  end
               end
            end
            RFILL: begin
               if (mem_ack) begin
                  state_nxt = IDLE;
                  mem_done  = 1'b1;
                  valid_wen = 1'b1;
                  valid_wr  = 1'b1;
                  tag_wen   = 1'b1;
                  data_wen  = 1'b1;
                  data_wr   = mem_rdata;
                  cpu_ready = 1'b1;
                  cpu_rdata = mem_rdata;
               end
            end
            WTHRU: begin
               if (mem_ack) begin
                  state_nxt = IDLE;
                  mem_done  = 1'b1;
                  cpu_ready = 1'b1;
               end
            end
            FLUSH: begin
               flush_busy = 1'b1;
               arr_index  = flush_cnt;
               valid_wen  = 1'b1;
               if (&flush_cnt) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         flush_cnt <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state <= state_nxt;
         // Wraps back to zero on the last flush cycle, ready for the next flush.
         if (state == FLUSH) begin
            flush_cnt <= flush_cnt + IDX_W'(1);
         end
         if (cnt_hit && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
         end
         if (cnt_miss && (miss_cnt != '1)) begin
            miss_cnt <= miss_cnt + CNT_W'(1);
         end
         if (mem_start) begin
            mem_req  <= 1'b1;
            mem_we   <= cpu_we;
            mem_addr <= {cpu_addr[31:2], 2'b00};
            if (cpu_we) begin
               mem_wdata <= cpu_wdata;
            end
         end else if (mem_done) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: behavioural valid/tag/data arrays, a memory
// responder with random latency, and a reference model of the cache contents
// and memory image. Expected load responses go into a scoreboard queue that a
// separate monitor drains whenever cpu_ready is seen.

module tb_dcache_ctrl;

   localparam int IDX_W   = 4;
   localparam int TAG_W   = 26;
   localparam int DATA_W  = 32;
   localparam int CNT_W   = 6;
   localparam int LINES   = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk;
   logic              rst;
   logic              cpu_req;
   logic              cpu_we;
   logic [31:0]       cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              flush;
   logic              flush_busy;
   logic [IDX_W-1:0]  arr_index;
   logic              valid_in;
   logic [TAG_W-1:0]  tag_in;
   logic [DATA_W-1:0] data_in;
   logic              valid_wen, valid_wr;
   logic              tag_wen;
   logic [TAG_W-1:0]  tag_wr;
   logic              data_wen;
   logic [DATA_W-1:0] data_wr;
   logic              mem_req, mem_we;
   logic [31:0]       mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic [CNT_W-1:0]  hit_cnt, miss_cnt;

   dcache_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .flush(flush), .flush_busy(flush_busy),
      .arr_index(arr_index), .valid_in(valid_in), .tag_in(tag_in), .data_in(data_in),
      .valid_wen(valid_wen), .valid_wr(valid_wr), .tag_wen(tag_wen), .tag_wr(tag_wr),
      .data_wen(data_wen), .data_wr(data_wr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External arrays, cleared (valid bits) by the same reset.
   logic              arr_valid [LINES];
   logic [TAG_W-1:0]  arr_tag   [LINES];
   logic [DATA_W-1:0] arr_data  [LINES];

   assign valid_in = arr_valid[arr_index];
   assign tag_in   = arr_tag[arr_index];
   assign data_in  = arr_data[arr_index];

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < LINES; i++) arr_valid[i] <= 1'b0;
      end else begin
         if (valid_wen) arr_valid[arr_index] <= valid_wr;
         if (tag_wen)   arr_tag[arr_index]   <= tag_wr;
         if (data_wen)  arr_data[arr_index]  <= data_wr;
      end
   end

   // Reference model: which word each line holds, plus the memory image.
   typedef struct packed {
      logic        we;
      logic        miss;
      logic [31:0] data;
   } exp_t;

   exp_t        sb [$];
   bit          ref_valid [LINES];
   logic [25:0] ref_tag   [LINES];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] ext_mem [logic [31:0]];
   int          exp_hit_cnt, exp_miss_cnt;

   int          checks, errors;
   int          ack_count;
   logic [31:0] cur_addr, cur_wdata;
   logic        cur_we;
   logic        hold_ack, force_ack;

   function automatic logic [31:0] init_word(input logic [31:0] wa);
      return (wa * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] wa);
      if (ref_mem.exists(wa)) return ref_mem[wa];
      return init_word(wa);
   endfunction

   function automatic logic [31:0] ext_read(input logic [31:0] wa);
      if (ext_mem.exists(wa)) return ext_mem[wa];
      return init_word(wa);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reset_ref();
      for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
      exp_hit_cnt  = 0;
      exp_miss_cnt = 0;
   endtask

   // Memory responder: acks each request after 0..3 extra cycles.
   initial begin
      int wait_left;
      wait_left = -1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      ack_count = 0;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
         end else if (mem_req && !hold_ack && rst) begin
            if (wait_left < 0) begin
               chk("mem_addr", 64'(mem_addr), 64'({cur_addr[31:2], 2'b00}));
               chk("mem_we", 64'(mem_we), 64'(cur_we));
               if (cur_we) chk("mem_wdata", 64'(mem_wdata), 64'(cur_wdata));
               wait_left = $urandom_range(0, 3);
            end
            if (wait_left == 0) begin
               mem_ack = 1'b1;
               if (mem_we) ext_mem[mem_addr] = mem_wdata;
               else        mem_rdata = ext_read(mem_addr);
               ack_count++;
               wait_left = -1;
            end else begin
               wait_left--;
            end
         end
      end
   end

   // Monitor: every completed access must match the oldest expectation.
   initial begin
      int   last_ack;
      exp_t e;
      last_ack = 0;
      forever begin
         @(negedge clk);
         if (rst && cpu_ready) begin
            chk("ready_has_request", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
               e = sb.pop_front();
               if (!e.we) chk("load_rdata", 64'(cpu_rdata), 64'(e.data));
               chk("went_to_memory", 64'(ack_count != last_ack), 64'(e.miss));
            end
            last_ack = ack_count;
         end
      end
   end

   task automatic start_access(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic store_hit);
      logic [31:0] wa;
      int          idx;
      logic [25:0] tg;
      bit          h;
      exp_t        e;
      wa  = {addr[31:2], 2'b00};
      idx = int'(addr[5:2]);
      tg  = addr[31:6];
      h   = ref_valid[idx] && (ref_tag[idx] == tg);
      e.we   = we;
      e.miss = we ? 1'b1 : !h;
      e.data = we ? 32'h0 : ref_read(wa);
      if (!we) begin
         if (h) begin
            if (exp_hit_cnt < CNT_MAX) exp_hit_cnt++;
         end else begin
            if (exp_miss_cnt < CNT_MAX) exp_miss_cnt++;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
         end
      end else begin
         ref_mem[wa] = wdata;
      end
      store_hit = we && h;
      sb.push_back(e);
      cur_addr  = addr;
      cur_we    = we;
      cur_wdata = wdata;
      cpu_addr  = addr;
      cpu_we    = we;
      cpu_wdata = wdata;
      cpu_req   = 1'b1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!cpu_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", 64'(cpu_ready), 64'(1));
      @(posedge clk); #1;
      cpu_req = 1'b0;
      chk("hit_cnt", 64'(hit_cnt), 64'(exp_hit_cnt));
      chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss_cnt));
   endtask

   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      logic sh;
      start_access(we, addr, wdata, sh);
      @(negedge clk);
      chk("accept_valid_wen", 64'(valid_wen), 64'(0));
      chk("accept_tag_wen", 64'(tag_wen), 64'(0));
      chk("accept_data_wen", 64'(data_wen), 64'(sh));
      if (sh) begin
         chk("store_hit_data_wr", 64'(data_wr), 64'(wdata));
         chk("store_hit_index", 64'(arr_index), 64'(addr[5:2]));
      end
      wait_ready();
   endtask

   task automatic flush_with_req(input logic [31:0] addr);
      logic sh;
      for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
      start_access(1'b0, addr, 32'h0, sh);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_priority_ready", 64'(cpu_ready), 64'(0));
      chk("flush_idle_busy", 64'(flush_busy), 64'(0));
      @(posedge clk); #1;
      flush = 1'b0;
      for (int k = 0; k < LINES; k++) begin
         @(negedge clk);
         chk("flush_busy", 64'(flush_busy), 64'(1));
         chk("flush_valid_wen", 64'(valid_wen), 64'(1));
         chk("flush_valid_wr", 64'(valid_wr), 64'(0));
         chk("flush_index", 64'(arr_index), 64'(k));
         chk("flush_ready", 64'(cpu_ready), 64'(0));
      end
      @(negedge clk);
      chk("flush_done_busy", 64'(flush_busy), 64'(0));
      wait_ready();
   endtask

   task automatic reset_mid_fill();
      int n;
      hold_ack  = 1'b1;
      cur_addr  = 32'h0F00_0300;
      cur_we    = 1'b0;
      cpu_addr  = 32'h0F00_0300;
      cpu_we    = 1'b0;
      cpu_req   = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_req && n < 20);
      chk("abort_mem_req_seen", 64'(mem_req), 64'(1));
      @(posedge clk); #1;
      rst     = 1'b0;
      cpu_req = 1'b0;
      @(negedge clk);
      chk("rst_ready", 64'(cpu_ready), 64'(0));
      chk("rst_wen", 64'({valid_wen, tag_wen, data_wen}), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      reset_ref();
      @(negedge clk);
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      chk("rst_hit_cnt", 64'(hit_cnt), 64'(0));
      chk("rst_miss_cnt", 64'(miss_cnt), 64'(0));
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      chk("late_ack_ready", 64'(cpu_ready), 64'(0));
      chk("late_ack_wen", 64'({valid_wen, tag_wen, data_wen}), 64'(0));
      @(negedge clk);
      chk("late_ack_mem_req", 64'(mem_req), 64'(0));
      hold_ack = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      checks    = 0;
      errors    = 0;
      rst       = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      flush     = 1'b0;
      hold_ack  = 1'b0;
      force_ack = 1'b0;
      cur_addr  = '0;
      cur_we    = 1'b0;
      cur_wdata = '0;
      reset_ref();
      ref_mem[32'h0000_0040] = 32'hDEAD_BEEF;
      ext_mem[32'h0000_0040] = 32'hDEAD_BEEF;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_mem_req", 64'(mem_req), 64'(0));
      chk("reset_mem_addr", 64'(mem_addr), 64'(0));
      chk("reset_counters", 64'({hit_cnt, miss_cnt}), 64'(0));
      chk("reset_flush_busy", 64'(flush_busy), 64'(0));
      chk("reset_ready", 64'(cpu_ready), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;

      do_access(1'b0, 32'h0000_0040, 32'h0);         // cold miss
      do_access(1'b0, 32'h0000_0040, 32'h0);         // hit
      do_access(1'b0, 32'h0000_0080, 32'h0);         // conflict miss
      do_access(1'b0, 32'h0000_0040, 32'h0);         // conflict miss again
      do_access(1'b0, 32'h0000_0080, 32'h0);
      do_access(1'b1, 32'h0000_0080, 32'h1234_5678); // store hit
      do_access(1'b0, 32'h0000_0080, 32'h0);
      do_access(1'b1, 32'h0000_0104, 32'hCAFE_F00D); // store miss, no allocate
      do_access(1'b0, 32'h0000_0104, 32'h0);
      flush_with_req(32'h0000_0080);
      do_access(1'b0, 32'h0000_0080, 32'h0);
      reset_mid_fill();
      do_access(1'b0, 32'h0000_0040, 32'h0);

      for (int k = 0; k < 400; k++) begin
         a = {26'($urandom_range(8, 11)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 49) == 0) flush_with_req(a);
         else do_access($urandom_range(0, 9) < 3, a, $urandom);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
